uart_rx_param: RTL

Parametrised UART receiver and next generation of the lab3 serial receiver. It oversamples the asynchronous serial input s_in and decodes frames of configurable width, parity and stop bits. Each frame ends in a one-cycle ready strobe with the received word and error flags. It sits between the board RX pin and the user logic / FIFO, all in the single clk domain.

---
 rtl/uart_rx_param.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: configurable data width, parity and stop bits.
// Emits a one-cycle ready strobe with the word and per-frame error flags.
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int BAUD_DIV   = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_in,
  output logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = 4;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BAUD_DIV - 1);
  localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY_BIT, STOP, WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, rx_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_int_q, perr_int_d;
  logic                 ferr_int_q, ferr_int_d;
  logic                 ready_q, ready_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 tick;

  // Odd mode flags an even count of ones over data+parity; even mode the reverse.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    logic odd_ones;
    odd_ones = ^{d, p};
    return (PARITY == 1) ? ~odd_ones : odd_ones;
  endfunction

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d      = state_q;
    div_d        = tick ? '0 : div_q + DIV_W'(1);
    os_d         = os_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    perr_int_d   = perr_int_q;
    ferr_int_d   = ferr_int_q;
    ready_d      = 1'b0;
    data_d       = data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        // Restart the tick divider so the start bit is phase-aligned.
        if (!rx_q) begin
          state_d = START;
          os_d    = '0;
          div_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (os_q == OS_HALF) begin
            if (rx_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              os_d    = '0;
              bit_d   = '0;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d = '0;
            sh_d = {rx_q, sh_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              bit_d      = '0;
              perr_int_d = 1'b0;
              ferr_int_d = 1'b0;
              state_d    = (PARITY != 0) ? PARITY_BIT : STOP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      PARITY_BIT: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d       = '0;
            perr_int_d = parity_bad(sh_q, rx_q);
            state_d    = STOP;
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d = '0;
            if (!rx_q) ferr_int_d = 1'b1;
            if (bit_q == STOP_LAST) begin
              bit_d        = '0;
              ready_d      = 1'b1;
              data_d       = sh_q;
              parity_err_d = perr_int_q;
              frame_err_d  = ferr_int_q | ~rx_q;
              state_d      = rx_q ? IDLE : WAIT_IDLE;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      WAIT_IDLE: begin
        // Line held low after a bad stop bit: wait for it to rise before rearming.
        if (rx_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      rx_q         <= 1'b1;
      div_q        <= '0;
      os_q         <= '0;
      bit_q        <= '0;
      perr_int_q   <= 1'b0;
      ferr_int_q   <= 1'b0;
      ready_q      <= 1'b0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= s_in;
      rx_q         <= sync1_q;
      div_q        <= div_d;
      os_q         <= os_d;
      bit_q        <= bit_d;
      perr_int_q   <= perr_int_d;
      ferr_int_q   <= ferr_int_d;
      ready_q      <= ready_d;
      data_q       <= data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign ready      = ready_q;
  assign data       = data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);
endmodule
